// File: rtl/seq_bin_to_ternary.sv
// seq_bin_to_ternary
// Iterative binary-to-base-3 converter. An unsigned WIDTH-bit value is
// accepted over a valid/ready handshake. The block then produces one base-3
// digit per clock by repeated divide-by-3, least significant digit first.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         synchronous active-high reset
//   in_valid    in_bin valid
//   in_ready    block can accept input (IDLE)
//   in_bin      unsigned value to convert
//   out_valid   result valid (DONE)
//   out_ready   consumer accepts result
//   out_digits  digit k at bits [2k+1:2k], k=0 is the ones digit
//               encoding 00=0, 01=1, 10=2 (11 never produced)
//   out_ovf     input not representable in DIGITS digits; out_digits then
//               holds the input mod 3^DIGITS
//   busy        conversion in progress (CONV)
module seq_bin_to_ternary #(
  parameter int WIDTH      = 16,
  parameter int DIGITS     = 11,
  parameter int EARLY_EXIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DIGITS-1:0]   out_digits,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(DIGITS - 1);
  localparam bit EARLY = (EARLY_EXIT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     val_q;
  logic [KW-1:0]        k_q;
  logic [2*DIGITS-1:0]  digits_q;
  logic                 ovf_q;

  // Combinational divide-by-3 of the working value; next val and digit.
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     rem_full;
  logic [1:0]           rem_d;
  logic                 last_d;

  always_comb begin
    quo_d    = val_q / WIDTH'(3);
    rem_full = val_q % WIDTH'(3);
    rem_d    = rem_full[1:0];
    // Stop after the top digit, or as soon as nothing is left to convert
    // when early exit is enabled.
    last_d   = (k_q == KLAST) || (EARLY && (quo_d == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            val_q    <= in_bin;
            digits_q <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_CONV;
          end
        end
        S_CONV: begin
          // Constant-index write keeps the digit select decode explicit.
          for (int i = 0; i < DIGITS; i++) begin
            if (k_q == KW'(i)) begin
              digits_q[2*i +: 2] <= rem_d;
            end
          end
          val_q <= quo_d;
          k_q   <= k_q + 1'b1;
          if (last_d) begin
            // Anything left in the quotient could not be represented.
            ovf_q   <= (quo_d != '0);
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q == S_CONV);
  assign out_valid  = (state_q == S_DONE);
  assign out_digits = digits_q;
  assign out_ovf    = ovf_q;

endmodule
